// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core, host loader) in front of a single-port
// synchronous data memory. Grants are combinational, round-robin on conflict,
// with a bounded burst lock and a one-cycle read-return path per requester.
module dmem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   // core port
   input  logic          c_req,
   input  logic          c_we,
   input  logic          c_lock,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   // host loader port
   input  logic          h_req,
   input  logic          h_we,
   input  logic          h_lock,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdata,
   // data memory
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

   owner_t     r_last_gnt;
   owner_t     w_last_gnt_nxt;
   logic [3:0] r_burst_cnt;
   logic [3:0] w_burst_cnt_nxt;
   logic       r_rd_pend_c;
   logic       r_rd_pend_h;
   logic       w_rd_pend_c_nxt;
   logic       w_rd_pend_h_nxt;
   logic       w_owner_req;
   logic       w_owner_lock;
   logic       w_lock_hold;
   logic       w_granted_lock;
   logic       w_gnt_c;
   logic       w_gnt_h;

   // Grant selection: locked owner first (until burst limit), else round-robin.
   always_comb begin
      w_gnt_c      = 1'b0;
      w_gnt_h      = 1'b0;
      w_owner_req  = (r_last_gnt == OWN_CORE) ? c_req  : h_req;
      w_owner_lock = (r_last_gnt == OWN_CORE) ? c_lock : h_lock;
      w_lock_hold  = w_owner_req && w_owner_lock && (r_burst_cnt < LP_MAX_BURST);
      if (RST_N) begin
         if (c_req && h_req) begin
            if (w_lock_hold) begin
               w_gnt_c = (r_last_gnt == OWN_CORE);
               w_gnt_h = (r_last_gnt == OWN_HOST);
            end else begin
               w_gnt_c = (r_last_gnt == OWN_HOST);
               w_gnt_h = (r_last_gnt == OWN_CORE);
            end
         end else begin
            w_gnt_c = c_req;
            w_gnt_h = h_req;
         end
      end
   end

   // Next-state: owner history, burst count and read-return tags.
   always_comb begin
      w_last_gnt_nxt  = r_last_gnt;
      w_burst_cnt_nxt = '0;
      w_granted_lock  = w_gnt_c ? c_lock : h_lock;
      w_rd_pend_c_nxt = w_gnt_c && !c_we;
      w_rd_pend_h_nxt = w_gnt_h && !h_we;
      if (w_gnt_c || w_gnt_h) begin
         w_last_gnt_nxt = w_gnt_c ? OWN_CORE : OWN_HOST;
         // A grant that used up the burst budget clears the count.
         if ((w_last_gnt_nxt == r_last_gnt) && w_granted_lock &&
             (r_burst_cnt < LP_MAX_BURST)) begin
            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
         end
      end
   end

   // State register; reset makes the core win the first conflict.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_last_gnt  <= OWN_HOST;
         r_burst_cnt <= '0;
         r_rd_pend_c <= 1'b0;
         r_rd_pend_h <= 1'b0;
      end else begin
         r_last_gnt  <= w_last_gnt_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_rd_pend_c <= w_rd_pend_c_nxt;
         r_rd_pend_h <= w_rd_pend_h_nxt;
      end
   end

   // Output muxing toward memory and read-return toward requesters.
   always_comb begin
      c_gnt     = w_gnt_c;
      h_gnt     = w_gnt_h;
      mem_en    = w_gnt_c | w_gnt_h;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_gnt_c) begin
         mem_we    = c_we;
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
      end else if (w_gnt_h) begin
         mem_we    = h_we;
         mem_addr  = h_addr;
         mem_wdata = h_wdata;
      end
      c_rvalid = r_rd_pend_c;
      h_rvalid = r_rd_pend_h;
      c_rdata  = r_rd_pend_c ? mem_rdata : '0;
      h_rdata  = r_rd_pend_h ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous memory.
module tb_dmem_arbiter;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       c_req, c_we, c_lock, h_req, h_we, h_lock;
   logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
   logic       c_gnt, c_rvalid, h_gnt, h_rvalid;
   logic [7:0] c_rdata, h_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0] mem [0:255];
   logic [37:0] w_act;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [2:0]  c_ctl;   // {req, we, lock}
      logic [7:0]  c_a;
      logic [7:0]  c_d;
      logic [2:0]  h_ctl;
      logic [7:0]  h_a;
      logic [7:0]  h_d;
      logic [37:0] exp;
   } vec_t;

   vec_t tbl [0:11];

   dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   // single-port synchronous memory: read data appears the cycle after issue
   always @(posedge CLK) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   assign w_act = {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_en, mem_we,
                   c_rdata, h_rdata, mem_addr, mem_wdata};

   // flags = {c_gnt, h_gnt, c_rvalid, h_rvalid, mem_we}; mem_en follows the grants
   function automatic logic [37:0] ex(input logic [4:0] f, input logic [7:0] crd,
                                      input logic [7:0] hrd, input logic [7:0] ma,
                                      input logic [7:0] mwd);
      return {f[4], f[3], f[2], f[1], f[4] | f[3], f[0], crd, hrd, ma, mwd};
   endfunction

   task automatic set_in(input logic [2:0] cc, input logic [7:0] ca, input logic [7:0] cd,
                         input logic [2:0] hc, input logic [7:0] ha, input logic [7:0] hd);
      {c_req, c_we, c_lock} = cc;
      c_addr  = ca;
      c_wdata = cd;
      {h_req, h_we, h_lock} = hc;
      h_addr  = ha;
      h_wdata = hd;
   endtask

   task automatic check(input string name, input logic [37:0] exp);
      n_vec++;
      if (w_act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (g_c g_h rv_c rv_h en we | crd hrd addr wd)",
                  name, w_act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      set_in(3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hA5;
      mem[8'h40] = 8'h77;
      mem_rdata  = 8'h00;

      tbl[0]  = '{3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b00000, 8'h00, 8'h00, 8'h00, 8'h00)};
      tbl[1]  = '{3'b100, 8'h10, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b10000, 8'h00, 8'h00, 8'h10, 8'h00)};
      tbl[2]  = '{3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b00100, 8'hA5, 8'h00, 8'h00, 8'h00)};
      tbl[3]  = '{3'b110, 8'h20, 8'h3C, 3'b000, 8'h00, 8'h00, ex(5'b10001, 8'h00, 8'h00, 8'h20, 8'h3C)};
      tbl[4]  = '{3'b100, 8'h20, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b10000, 8'h00, 8'h00, 8'h20, 8'h00)};
      tbl[5]  = '{3'b000, 8'h00, 8'h00, 3'b110, 8'h30, 8'h55, ex(5'b01101, 8'h3C, 8'h00, 8'h30, 8'h55)};
      tbl[6]  = '{3'b100, 8'h30, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b10000, 8'h00, 8'h00, 8'h30, 8'h00)};
      tbl[7]  = '{3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b00100, 8'h55, 8'h00, 8'h00, 8'h00)};
      tbl[8]  = '{3'b100, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, ex(5'b01000, 8'h00, 8'h00, 8'h30, 8'h00)};
      tbl[9]  = '{3'b100, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, ex(5'b10010, 8'h00, 8'h55, 8'h10, 8'h00)};
      tbl[10] = '{3'b100, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00, ex(5'b01100, 8'hA5, 8'h00, 8'h30, 8'h00)};
      tbl[11] = '{3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, ex(5'b00010, 8'h00, 8'h55, 8'h00, 8'h00)};

      // reset state with both requesters asking to write
      RST_N = 1'b0;
      set_in(3'b110, 8'h12, 8'h34, 3'b110, 8'h56, 8'h78);
      @(negedge CLK);
      #2 check("reset_state", ex(5'b00000, 8'h00, 8'h00, 8'h00, 8'h00));
      set_in(3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00);
      @(negedge CLK);
      RST_N = 1'b1;

      // table: single read, write/read back-to-back, read return + host write, round-robin
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         set_in(tbl[i].c_ctl, tbl[i].c_a, tbl[i].c_d, tbl[i].h_ctl, tbl[i].h_a, tbl[i].h_d);
         #2 check($sformatf("tbl%0d", i), tbl[i].exp);
      end

      // both read every cycle from reset: core, host, core, host
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         set_in(3'b100, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00);
         if (k % 2 == 0)
            #2 check($sformatf("rr%0d", k), ex({3'b100, k > 0, 1'b0}, 8'h00,
                                                (k > 0) ? 8'h55 : 8'h00, 8'h10, 8'h00));
         else
            #2 check($sformatf("rr%0d", k), ex(5'b01100, 8'hA5, 8'h00, 8'h30, 8'h00));
      end

      // host locked write burst vs. continuous core read: H H H H C H
      do_reset();
      begin
         logic [7:0] hi;
         hi = 8'h00;
         for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            set_in(3'b100, 8'h40, 8'h00, 3'b111, hi, 8'hB0 + hi);
            if (k == 4) begin
               #2 check($sformatf("burst%0d", k), ex(5'b10000, 8'h00, 8'h00, 8'h40, 8'h00));
            end else begin
               #2 check($sformatf("burst%0d", k),
                        ex({2'b01, k == 5, 2'b01}, (k == 5) ? 8'h77 : 8'h00, 8'h00, hi, 8'hB0 + hi));
               hi = hi + 8'h01;
            end
         end
      end

      // read accepted, then reset asserted half a cycle later
      do_reset();
      @(negedge CLK);
      set_in(3'b100, 8'h10, 8'h00, 3'b000, 8'h00, 8'h00);
      #2 check("rst_rd_gnt", ex(5'b10000, 8'h00, 8'h00, 8'h10, 8'h00));
      @(negedge CLK);
      RST_N = 1'b0;
      set_in(3'b100, 8'h10, 8'h00, 3'b100, 8'h30, 8'h00);
      #2 check("rst_mid", ex(5'b00000, 8'h00, 8'h00, 8'h00, 8'h00));
      @(negedge CLK);
      #2 check("rst_hold", ex(5'b00000, 8'h00, 8'h00, 8'h00, 8'h00));
      @(negedge CLK);
      RST_N = 1'b1;
      #2 check("rst_first_conflict", ex(5'b10000, 8'h00, 8'h00, 8'h10, 8'h00));
      @(negedge CLK);
      #2 check("rst_after", ex(5'b01100, 8'hA5, 8'h00, 8'h30, 8'h00));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
